// File: rtl/letter_seg_capture.sv
// Loopback monitor for the multiplexed letter-glyph seven-segment bus: filters scan ghosting and decodes each stable digit.
// Optional input synchronizer enabled by defining LETTER_SEG_CAPTURE_SYNC_EN.
//
// state  | meaning
// IDLE   | incoming an is not one-hot-low; counter held at 0
// TRACK  | one-hot value seen, counting repeat captures toward a commit
// HOLD   | committed value still present; counter saturated, no re-commit
module letter_seg_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    input  logic        clr,
    output logic [15:0] letters,
    output logic [3:0]  valid,
    output logic        upd,
    output logic [1:0]  upd_idx,
    output logic        glyph_err
);

    localparam logic [10:0] SAMP_RST  = {4'b1111, 7'h00};
    localparam logic [7:0]  STABLE_TC = 8'(STABLE_CYCLES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [10:0] in_w;

`ifdef LETTER_SEG_CAPTURE_SYNC_EN
    logic [10:0] sync1_d, sync1_q;
    logic [10:0] sync2_d, sync2_q;

    always_comb begin
        sync1_d = {an, seg};
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= SAMP_RST;
            sync2_q <= SAMP_RST;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign in_w = sync2_q;
`else
    assign in_w = {an, seg};
`endif

    logic [10:0] samp_d, samp_q;
    logic [1:0]  state_d, state_q;
    logic [7:0]  cnt_d, cnt_q;
    logic [15:0] letters_d, letters_q;
    logic [3:0]  valid_d, valid_q;
    logic        upd_d, upd_q;
    logic [1:0]  upd_idx_d, upd_idx_q;
    logic        err_d, err_q;

    logic [3:0]  in_an;
    logic [6:0]  in_seg;
    logic        one_hot;
    logic [1:0]  in_idx;
    logic        same;
    logic        commit;
    logic [3:0]  glyph_code;
    logic        glyph_legal;
    logic        glyph_blank;
    logic [7:0]  cnt_inc;

    assign in_an   = in_w[10:7];
    assign in_seg  = in_w[6:0];
    assign same    = (in_w == samp_q);
    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        one_hot = 1'b1;
        in_idx  = 2'd0;
        case (in_an)
            4'b1110: in_idx = 2'd0;
            4'b1101: in_idx = 2'd1;
            4'b1011: in_idx = 2'd2;
            4'b0111: in_idx = 2'd3;
            default: one_hot = 1'b0;
        endcase
    end

    always_comb begin
        glyph_code  = 4'd0;
        glyph_legal = 1'b1;
        glyph_blank = 1'b0;
        case (in_seg)
            7'h77: glyph_code = 4'd0;
            7'h1F: glyph_code = 4'd1;
            7'h4E: glyph_code = 4'd2;
            7'h3D: glyph_code = 4'd3;
            7'h4F: glyph_code = 4'd4;
            7'h47: glyph_code = 4'd5;
            7'h5E: glyph_code = 4'd6;
            7'h37: glyph_code = 4'd7;
            7'h3C: glyph_code = 4'd8;
            7'h0E: glyph_code = 4'd9;
            7'h15: glyph_code = 4'd10;
            7'h1D: glyph_code = 4'd11;
            7'h67: glyph_code = 4'd12;
            7'h05: glyph_code = 4'd13;
            7'h5B: glyph_code = 4'd14;
            7'h3B: glyph_code = 4'd15;
            7'h00: begin
                glyph_legal = 1'b0;
                glyph_blank = 1'b1;
            end
            default: glyph_legal = 1'b0;
        endcase
    end

    // The FSM looks at the value being captured this edge against the one already
    // in the sample register, so a commit also requires the capture on the commit edge.
    always_comb begin
        samp_d  = in_w;
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        if (!one_hot) begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_TRACK;
                    cnt_d   = 8'd0;
                end
                ST_TRACK: begin
                    if (same) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == STABLE_TC) begin
                            commit  = 1'b1;
                            state_d = ST_HOLD;
                        end
                    end else begin
                        cnt_d = 8'd0;
                    end
                end
                ST_HOLD: begin
                    if (!same) begin
                        state_d = ST_TRACK;
                        cnt_d   = 8'd0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        letters_d = letters_q;
        valid_d   = valid_q;
        upd_d     = commit;
        upd_idx_d = upd_idx_q;
        err_d     = clr ? 1'b0 : err_q;
        if (commit) begin
            upd_idx_d = in_idx;
            if (glyph_blank) begin
                letters_d[4*in_idx +: 4] = 4'd0;
                valid_d[in_idx]          = 1'b0;
            end else if (glyph_legal) begin
                letters_d[4*in_idx +: 4] = glyph_code;
                valid_d[in_idx]          = 1'b1;
            end else begin
                // letters keep their old code; the error beats a same-cycle clr
                valid_d[in_idx] = 1'b0;
                err_d           = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q    <= SAMP_RST;
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            letters_q <= 16'd0;
            valid_q   <= 4'd0;
            upd_q     <= 1'b0;
            upd_idx_q <= 2'd0;
            err_q     <= 1'b0;
        end else begin
            samp_q    <= samp_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            letters_q <= letters_d;
            valid_q   <= valid_d;
            upd_q     <= upd_d;
            upd_idx_q <= upd_idx_d;
            err_q     <= err_d;
        end
    end

    assign letters   = letters_q;
    assign valid     = valid_q;
    assign upd       = upd_q;
    assign upd_idx   = upd_idx_q;
    assign glyph_err = err_q;

endmodule

// File: tb/tb_letter_seg_capture.sv
// Directed bench for letter_seg_capture with STABLE_CYCLES=4.
module tb_letter_seg_capture;

    localparam int S = 4;
`ifdef LETTER_SEG_CAPTURE_SYNC_EN
    localparam int LAT = S + 2;
`else
    localparam int LAT = S;
`endif

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        clr;
    logic [15:0] letters;
    logic [3:0]  valid;
    logic        upd;
    logic [1:0]  upd_idx;
    logic        glyph_err;

    int tests;
    int fails;

    letter_seg_capture #(.STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg       (seg),
        .an        (an),
        .clr       (clr),
        .letters   (letters),
        .valid     (valid),
        .upd       (upd),
        .upd_idx   (upd_idx),
        .glyph_err (glyph_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        an    = 4'b1111;
        seg   = 7'h00;
        clr   = 1'b0;
        step();
        step();
        chk("rst_letters", 32'(letters), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_upd", 32'(upd), 32'h0);
        chk("rst_upd_idx", 32'(upd_idx), 32'h0);
        chk("rst_err", 32'(glyph_err), 32'h0);
        rst_n = 1'b1;
        step();
        step();

        // digit 0 'S' held long: exactly one pulse at E0+LAT
        an  = 4'b1110;
        seg = 7'h5B;
        for (int k = 1; k <= LAT + 4; k++) begin
            step();
            chk("s1_upd", 32'(upd), 32'(k == LAT + 1));
            if (k == LAT + 1) begin
                chk("s1_idx", 32'(upd_idx), 32'h0);
                chk("s1_letters", 32'(letters), 32'h000E);
                chk("s1_valid", 32'(valid), 32'h1);
            end
        end
        an = 4'b1111;
        step();
        step();

        // 'J' held 3 captures, then exactly S captures: neither commits
        an  = 4'b1011;
        seg = 7'h3C;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("s2_short_upd", 32'(upd), 32'h0);
        end
        an = 4'b1111;
        for (int k = 1; k <= LAT + 2; k++) begin
            step();
            chk("s2_tail_upd", 32'(upd), 32'h0);
        end
        an = 4'b1011;
        for (int k = 1; k <= S; k++) begin
            step();
            chk("s2_edge_upd", 32'(upd), 32'h0);
        end
        an = 4'b1111;
        for (int k = 1; k <= LAT + 2; k++) begin
            step();
            chk("s2_edge_tail_upd", 32'(upd), 32'h0);
        end
        chk("s2_letters", 32'(letters), 32'h000E);
        chk("s2_valid", 32'(valid), 32'h1);

        // illegal glyph on digit 3
        an  = 4'b0111;
        seg = 7'h7F;
        for (int k = 1; k <= LAT + 2; k++) begin
            step();
            chk("s3_upd", 32'(upd), 32'(k == LAT + 1));
            if (k == LAT + 1) begin
                chk("s3_idx", 32'(upd_idx), 32'h3);
                chk("s3_valid", 32'(valid), 32'h1);
                chk("s3_letters", 32'(letters), 32'h000E);
                chk("s3_err", 32'(glyph_err), 32'h1);
            end
        end
        chk("s3_err_sticky", 32'(glyph_err), 32'h1);
        an  = 4'b1111;
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("s3_clr", 32'(glyph_err), 32'h0);
        step();

        // clr on the very commit edge: error wins
        an  = 4'b0111;
        seg = 7'h7F;
        repeat (LAT) step();
        chk("s3b_err_pre", 32'(glyph_err), 32'h0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("s3b_upd", 32'(upd), 32'h1);
        chk("s3b_err", 32'(glyph_err), 32'h1);
        an = 4'b1111;
        step();
        step();

        // digit 1: 'a', then 'e' without leaving HOLD, two-low ghost, then blank
        an  = 4'b1101;
        seg = 7'h77;
        repeat (LAT) step();
        step();
        chk("s4a_upd", 32'(upd), 32'h1);
        chk("s4a_idx", 32'(upd_idx), 32'h1);
        chk("s4a_valid", 32'(valid), 32'h3);
        chk("s4a_letters", 32'(letters), 32'h000E);
        step();
        chk("s4a_upd_low", 32'(upd), 32'h0);
        seg = 7'h4F;
        repeat (LAT) step();
        step();
        chk("s4b_upd", 32'(upd), 32'h1);
        chk("s4b_letters", 32'(letters), 32'h004E);
        chk("s4b_valid", 32'(valid), 32'h3);
        an = 4'b1100;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("s4c_upd", 32'(upd), 32'h0);
        end
        chk("s4c_letters", 32'(letters), 32'h004E);
        chk("s4c_valid", 32'(valid), 32'h3);
        an  = 4'b1101;
        seg = 7'h00;
        repeat (LAT) step();
        step();
        chk("s4d_upd", 32'(upd), 32'h1);
        chk("s4d_idx", 32'(upd_idx), 32'h1);
        chk("s4d_valid", 32'(valid), 32'h1);
        chk("s4d_letters", 32'(letters), 32'h000E);
        an = 4'b1111;
        step();
        step();

        // reset mid-track discards progress; fresh run after release
        an  = 4'b1110;
        seg = 7'h3B;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("s5_rst_letters", 32'(letters), 32'h0);
        chk("s5_rst_valid", 32'(valid), 32'h0);
        chk("s5_rst_upd", 32'(upd), 32'h0);
        chk("s5_rst_idx", 32'(upd_idx), 32'h0);
        chk("s5_rst_err", 32'(glyph_err), 32'h0);
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= LAT + 2; k++) begin
            step();
            chk("s5_upd", 32'(upd), 32'(k == LAT + 1));
            if (k == LAT + 1) begin
                chk("s5_letters", 32'(letters), 32'h000F);
                chk("s5_valid", 32'(valid), 32'h1);
                chk("s5_idx", 32'(upd_idx), 32'h0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
